// File: rtl/module_multiplier.sv
// module_multiplier: sequential shift-and-add unsigned multiplier, one operand bit per clock.
//   clk, rst            : clock, asynchronous active-high reset
//   multiplicand, multiplier, in_valid / in_ready : operand handshake (accepted in IDLE only)
//   product, out_valid / out_ready                : 2*DATAWIDTH-bit result handshake (held in DONE)
module module_multiplier #(
   parameter int DATAWIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATAWIDTH-1:0]   multiplicand,
   input  logic [DATAWIDTH-1:0]   multiplier,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [2*DATAWIDTH-1:0] product,
   output logic                   out_valid,
   input  logic                   out_ready
);
   localparam int CW = $clog2(DATAWIDTH) + 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t                 state_q, state_d;
   logic [2*DATAWIDTH-1:0] a_q, a_d, acc_q, acc_d, product_q, product_d, sum;
   logic [DATAWIDTH-1:0]   b_q, b_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   accept, last;
   assign accept = state_q == IDLE && in_valid;
   assign last   = cnt_q == CW'(DATAWIDTH - 1);
   // Partial sum for this iteration; also the final product on the last CALC edge.
   assign sum    = acc_q + (b_q[0] ? a_q : '0);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end
   always_comb begin
      state_d = accept                           ? CALC :
                (state_q == CALC && last)        ? DONE :
                (state_q == DONE && out_ready)   ? IDLE : state_q;
   end
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      if (accept) begin
         a_d   = {{DATAWIDTH{1'b0}}, multiplicand};
         b_d   = multiplier;
         acc_d = '0;
         cnt_d = '0;
      end else if (state_q == CALC) begin
         acc_d     = sum;
         a_d       = a_q << 1;
         b_d       = b_q >> 1;
         cnt_d     = cnt_q + 1'b1;
         product_d = last ? sum : product_q;
      end
   end
   always_comb begin
      in_ready  = state_q == IDLE;
      out_valid = state_q == DONE;
      product   = product_q;
   end
endmodule

// File: tb/tb_module_multiplier.sv
// tb_module_multiplier: scoreboard bench for module_multiplier (DATAWIDTH=24 plus a DATAWIDTH=1 instance).
module tb_module_multiplier;
   localparam int W = 24;
   logic           clk = 0;
   logic           rst;
   logic [W-1:0]   multiplicand, multiplier;
   logic           in_valid, in_ready, out_valid, out_ready;
   logic [2*W-1:0] product;
   logic           a1, b1, iv1, ir1, ov1, or1;
   logic [1:0]     p1;
   int             checks = 0, errs = 0;
   logic [2*W-1:0] exp_q[$];
   bit             rnd = 0;

   module_multiplier #(.DATAWIDTH(W)) dut (
      .clk(clk), .rst(rst), .multiplicand(multiplicand), .multiplier(multiplier),
      .in_valid(in_valid), .in_ready(in_ready), .product(product),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   module_multiplier #(.DATAWIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .multiplicand(a1), .multiplier(b1),
      .in_valid(iv1), .in_ready(ir1), .product(p1),
      .out_valid(ov1), .out_ready(or1)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      logic [2*W-1:0] ea, eb;
      ea = {{W{1'b0}}, a};
      eb = {{W{1'b0}}, b};
      in_valid = 1;
      multiplicand = a;
      multiplier = b;
      n = 0;
      while (!in_ready && n < 500) begin
         tick();
         n++;
      end
      chk("accept_in_time", 64'(n < 500), 64'd1);
      if (n < 500) exp_q.push_back(ea * eb);
      tick();
      in_valid = 0;
      multiplicand = W'($urandom);
      multiplier = W'($urandom);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!out_valid && n < 200);
   endtask

   // Monitor: every consumed product is popped and compared in order.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_output: got %0h with nothing outstanding", product);
         end else chk("product", 64'(product), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [2*W-1:0] hold;
      rst = 1; in_valid = 0; out_ready = 0; multiplicand = 0; multiplier = 0;
      iv1 = 0; or1 = 0; a1 = 0; b1 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_product", 64'(product), 64'd0);
      chk("reset_w1_in_ready", 64'(ir1), 64'd1);
      @(negedge clk) rst = 0;
      tick();
      out_ready = 1;
      send(24'd1000, 24'd3000);
      wait_valid(n);
      chk("latency_basic", 64'(n), 64'd24);
      chk("product_basic", 64'(product), 64'd3000000);
      tick();
      chk("in_ready_after_consume", 64'(in_ready), 64'd1);
      send(24'hFFFFFF, 24'hFFFFFF);
      wait_valid(n);
      chk("product_max", 64'(product), 64'hFFFFFE000001);
      tick();
      send(24'd0, 24'h123456);
      wait_valid(n);
      chk("latency_zero", 64'(n), 64'd24);
      tick();
      out_ready = 0;
      send(24'd12345, 24'd678);
      wait_valid(n);
      hold = product;
      for (int i = 0; i < 10; i++) begin
         in_valid = ~in_valid;
         multiplicand = W'($urandom);
         multiplier = W'($urandom);
         tick();
         chk("bp_product_stable", 64'(product), 64'(hold));
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 0;
      out_ready = 1;
      tick();
      chk("consume_out_valid", 64'(out_valid), 64'd0);
      chk("consume_in_ready", 64'(in_ready), 64'd1);
      chk("single_consume", 64'(exp_q.size()), 64'd0);
      send(24'd3, 24'd5);
      chk("next_accepted", 64'(in_ready), 64'd0);
      wait_valid(n);
      tick();
      send(24'd99, 24'd77);
      repeat (12) tick();
      #2 rst = 1;
      #1;
      chk("midreset_in_ready", 64'(in_ready), 64'd1);
      chk("midreset_out_valid", 64'(out_valid), 64'd0);
      chk("midreset_product", 64'(product), 64'd0);
      exp_q.delete();
      @(negedge clk) rst = 0;
      tick();
      send(24'd7, 24'd6);
      wait_valid(n);
      chk("latency_after_reset", 64'(n), 64'd24);
      chk("product_after_reset", 64'(product), 64'd42);
      tick();
      chk("no_stale_result", 64'(exp_q.size()), 64'd0);
      rnd = 1;
      for (int i = 0; i < 200; i++) begin
         int d, q;
         repeat ($urandom_range(0, 2)) tick();
         if (i % 4 == 0) begin
            d = int'($urandom_range(1, 4095));
            q = int'($urandom_range(0, 32'((2 ** 24 - 1) / d)));
            send(W'(q), W'(d));
         end else if (i % 25 == 1) send(24'hFFFFFF, W'($urandom));
         else send(W'($urandom), W'($urandom));
      end
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      chk("stream_drained", 64'(exp_q.size()), 64'd0);
      rnd = 0;
      or1 = 1;
      for (int a = 0; a < 2; a++) begin
         for (int b = 0; b < 2; b++) begin
            a1 = 1'(a);
            b1 = 1'(b);
            iv1 = 1;
            tick();
            iv1 = 0;
            tick();
            chk("w1_out_valid", 64'(ov1), 64'd1);
            chk("w1_product", 64'(p1), 64'(a * b));
            tick();
            chk("w1_in_ready", 64'(ir1), 64'd1);
         end
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/module_multiplier.md
Name: module_multiplier

Overview:
- Sequential shift-and-add unsigned multiplier; the inverse arithmetic block to the team's combinational restoring divider.
- Used on the same DATAWIDTH-wide datapath wherever a scaled value must be rebuilt from a quotient and divisor (quotient * divisor).
- Takes one operand pair per valid/ready handshake, iterates one bit per clock, and holds the full-width product until the consumer accepts it.

Parameters:
- DATAWIDTH, 24, width of each unsigned operand; the product is 2*DATAWIDTH wide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- multiplicand  input  DATAWIDTH  unsigned operand A
- multiplier  input  DATAWIDTH  unsigned operand B
- in_valid  input  1  operands are valid
- in_ready  output  1  block can accept operands
- product  output  2*DATAWIDTH  unsigned A*B, exact with no truncation
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts the product

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, product=0, counter=0, internal operand registers=0. Reset applies immediately, including mid-calculation or while the result is held; any operation in flight is discarded without an output.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a rising edge with in_valid=1, latch A into a 2*DATAWIDTH shift register (zero-extended) and B into a DATAWIDTH shift register.
  - On that same edge, clear the accumulator and counter, and go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge: if B[0]=1, acc <= acc + A (2*DATAWIDTH-bit add; it cannot overflow). Then A <= A<<1, B <= B>>1, counter <= counter+1.
  - After exactly DATAWIDTH iterations, load product <= final acc and go to DONE.
  - There is no early exit when B becomes zero; latency is fixed.
- DONE:
  - out_valid=1, in_ready=0. product is stable and must not change while out_valid=1.
  - On an edge with out_ready=1, go to IDLE; out_valid falls and in_ready rises on that edge.
  - out_ready=0 holds DONE indefinitely.
- Latency: the operand-accept edge is E0. out_valid is 1 after edge E(DATAWIDTH). The minimum initiation interval is DATAWIDTH+2 cycles (accept, DATAWIDTH CALC edges, one DONE edge with out_ready=1).
- Handshake rules:
  - in_valid and operands are ignored outside IDLE.
  - Operands may change freely after the accept edge.
  - out_ready is ignored outside DONE.
  - A new operand pair cannot be accepted on the same edge that the product is consumed. It is accepted no earlier than the following edge.
- product holds its last value after consumption until the next CALC completion. Consumers must qualify it with out_valid.
- Counter width: $clog2(DATAWIDTH)+1 bits, and it must not wrap before DATAWIDTH is reached.
- Boundary values:
  - A=0 or B=0 gives product 0 with normal latency.
  - Maximum operands give (2^DATAWIDTH-1)^2 exactly.
  - DATAWIDTH=1 must work (1 CALC cycle).
- Consistency check: for B!=0 and A=B*Q with Q<2^DATAWIDTH, product[DATAWIDTH-1:0] equals A.

Test Plan:
- Reset then A=24'd1000, B=24'd3000, in_valid pulse, out_ready=1 -> out_valid rises exactly 24 edges after accept; product=48'd3000000; in_ready=1 on the following cycle.
- A=24'hFFFFFF, B=24'hFFFFFF -> product=48'hFFFFFE000001. A=0, B=24'h123456 -> product=0 with identical 24-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and changing operands -> product stable, in_ready=0, no new accept. Raise out_ready -> single consume, then the next pair is accepted one edge later.
- Assert rst at CALC iteration 12 -> all outputs return to reset values immediately. Release rst, then A=7, B=6 -> product=42 with full 24-cycle latency and no stale result.
- Back-to-back stream of 200 random pairs with random in_valid/out_ready stalls -> every product matches a reference model, in order, with none dropped or duplicated.
- Round-trip: feed divisor and divider quotient for random pairs with exact division -> product[23:0] equals the original dividend. Repeat with DATAWIDTH=1 and DATAWIDTH=8 builds -> exhaustive 8-bit products correct.
